// File: rtl/eprisc_bus_arbiter.sv
// Round-robin owner of the 8-bit system I/O bus for the core (req0) and DMA/loader (req1).
// Sequences each granted transaction byte by byte and hands the MISO byte back to the owner.
module eprisc_bus_arbiter #(
    parameter int CLKDIV = 2
) (
    input  logic        iBoardClock,
    input  logic        iBoardReset,
    input  logic [1:0]  iReqRequest,
    input  logic [3:0]  iReqSelect,
    input  logic [15:0] iReqData,
    input  logic [1:0]  iReqValid,
    input  logic [1:0]  iReqLast,
    output logic [1:0]  oReqGrant,
    output logic [1:0]  oReqReady,
    output logic [1:0]  oReqStrobe,
    output logic [7:0]  oReqData,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO
);
    typedef enum logic [2:0] {sIdle, sGrant, sWait, sLow, sHigh, sDone} state_t;

    localparam logic [7:0] phaseReload = 8'(CLKDIV - 1);

    state_t     state;
    logic       owner;
    logic       lastOwner;
    logic       lastFlag;
    logic [7:0] phaseCount;
    logic [7:0] misoCapture;
    logic [1:0] ownerMask;
    logic       nextOwner;

    assign ownerMask = owner ? 2'b10 : 2'b01;

    // Contention goes to whichever master did not own the bus last.
    always_comb begin
        nextOwner = iReqRequest[1];
        if (&iReqRequest) nextOwner = ~lastOwner;
    end

    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) begin
            state       <= sIdle;
            owner       <= 1'b0;
            lastOwner   <= 1'b1;
            lastFlag    <= 1'b0;
            phaseCount  <= 8'd0;
            misoCapture <= 8'd0;
            oReqGrant   <= 2'b00;
            oReqReady   <= 2'b00;
            oReqStrobe  <= 2'b00;
            oReqData    <= 8'd0;
            oBusClock   <= 1'b0;
            oBusSelect  <= 2'b00;
            oBusMOSI    <= 8'd0;
        end else begin
            oReqStrobe <= 2'b00;
            case (state)
                sIdle: begin
                    if (|iReqRequest) begin
                        owner      <= nextOwner;
                        oReqGrant  <= nextOwner ? 2'b10 : 2'b01;
                        oBusSelect <= nextOwner ? iReqSelect[3:2] : iReqSelect[1:0];
                        state      <= sGrant;
                    end
                end
                sGrant: begin
                    oReqReady <= ownerMask;
                    state     <= sWait;
                end
                sWait: begin
                    // An offered byte wins over a request drop in the same cycle.
                    if (iReqValid[owner]) begin
                        oBusMOSI   <= owner ? iReqData[15:8] : iReqData[7:0];
                        lastFlag   <= iReqLast[owner];
                        oReqReady  <= 2'b00;
                        phaseCount <= phaseReload;
                        state      <= sLow;
                    end else if (!iReqRequest[owner]) begin
                        oReqReady  <= 2'b00;
                        oReqGrant  <= 2'b00;
                        oBusSelect <= 2'b00;
                        state      <= sDone;
                    end
                end
                sLow: begin
                    if (phaseCount == 8'd0) begin
                        oBusClock   <= 1'b1;
                        misoCapture <= iBusMISO;
                        phaseCount  <= phaseReload;
                        state       <= sHigh;
                    end else begin
                        phaseCount <= phaseCount - 8'd1;
                    end
                end
                sHigh: begin
                    if (phaseCount == 8'd0) begin
                        oBusClock  <= 1'b0;
                        oReqData   <= misoCapture;
                        oReqStrobe <= ownerMask;
                        if (lastFlag) begin
                            oReqGrant  <= 2'b00;
                            oBusSelect <= 2'b00;
                            state      <= sDone;
                        end else begin
                            oReqReady <= ownerMask;
                            state     <= sWait;
                        end
                    end else begin
                        phaseCount <= phaseCount - 8'd1;
                    end
                end
                sDone: begin
                    lastOwner <= owner;
                    state     <= sIdle;
                end
                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Bench for eprisc_bus_arbiter: two instances (CLKDIV 2 and 1) checked every cycle against a
// byte-age timing model, plus directed scenarios with literal expectations and random traffic.
module tb_eprisc_bus_arbiter;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req[2], valid[2], last[2], gnt[2], rdy[2], stb[2], bsel[2];
    logic [3:0]  sel[2];
    logic [15:0] data[2];
    logic [7:0]  miso[2], rdat[2], mosi[2];
    logic        bclk[2];
    int checks = 0;
    int failures = 0;

    eprisc_bus_arbiter #(.CLKDIV(2)) dut0 (
        .iBoardClock(clk), .iBoardReset(rstN), .iReqRequest(req[0]), .iReqSelect(sel[0]),
        .iReqData(data[0]), .iReqValid(valid[0]), .iReqLast(last[0]), .oReqGrant(gnt[0]),
        .oReqReady(rdy[0]), .oReqStrobe(stb[0]), .oReqData(rdat[0]), .oBusClock(bclk[0]),
        .oBusSelect(bsel[0]), .oBusMOSI(mosi[0]), .iBusMISO(miso[0]));
    eprisc_bus_arbiter #(.CLKDIV(1)) dut1 (
        .iBoardClock(clk), .iBoardReset(rstN), .iReqRequest(req[1]), .iReqSelect(sel[1]),
        .iReqData(data[1]), .iReqValid(valid[1]), .iReqLast(last[1]), .oReqGrant(gnt[1]),
        .oReqReady(rdy[1]), .oReqStrobe(stb[1]), .oReqData(rdat[1]), .oBusClock(bclk[1]),
        .oBusSelect(bsel[1]), .oBusMOSI(mosi[1]), .iBusMISO(miso[1]));

    // Model: owner (-1 free), edges since byte accepted (-1 none), last granted master.
    int         div[2] = '{2, 1};
    int         own[2], age[2], lastG[2];
    bit         fresh[2], closing[2], endTx[2];
    logic [1:0] eG[2], eR[2], eS[2], eSel[2];
    logic [7:0] eD[2], eM[2], cap[2];
    logic       eC[2];

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h expected=%h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic modelReset(input int d);
        own[d] = -1; age[d] = -1; lastG[d] = -1;
        fresh[d] = 0; closing[d] = 0; endTx[d] = 0;
        eG[d] = 0; eR[d] = 0; eS[d] = 0; eSel[d] = 0;
        eD[d] = 0; eM[d] = 0; cap[d] = 0; eC[d] = 0;
    endtask

    task automatic finishTx(input int d);
        closing[d] = 1; eG[d] = 0; eSel[d] = 0; eR[d] = 0;
    endtask

    task automatic modelStep(input int d);
        int g;
        eS[d] = 0;
        if (closing[d]) begin
            closing[d] = 0;
            own[d] = -1;
        end else if (own[d] < 0) begin
            if (req[d] != 2'b00) begin
                if (req[d] == 2'b11) g = (lastG[d] == 0) ? 1 : 0;
                else g = req[d][1] ? 1 : 0;
                own[d] = g; lastG[d] = g; fresh[d] = 1;
                eG[d] = 2'(1 << g);
                eSel[d] = sel[d][2*g +: 2];
            end
        end else if (fresh[d]) begin
            fresh[d] = 0;
            eR[d] = 2'(1 << own[d]);
        end else if (age[d] < 0) begin
            if (valid[d][own[d]]) begin
                age[d] = 0;
                eM[d] = data[d][8*own[d] +: 8];
                endTx[d] = last[d][own[d]];
                eR[d] = 0;
            end else if (!req[d][own[d]]) begin
                finishTx(d);
            end
        end else begin
            age[d]++;
            if (age[d] == div[d]) begin
                eC[d] = 1;
                cap[d] = miso[d];
            end
            if (age[d] == 2 * div[d]) begin
                eC[d] = 0; eD[d] = cap[d]; eS[d] = 2'(1 << own[d]); age[d] = -1;
                if (endTx[d]) finishTx(d);
                else eR[d] = 2'(1 << own[d]);
            end
        end
    endtask

    task automatic compareAll(input int d);
        chk("grant", d, 8'(gnt[d]), 8'(eG[d]));
        chk("ready", d, 8'(rdy[d]), 8'(eR[d]));
        chk("strobe", d, 8'(stb[d]), 8'(eS[d]));
        chk("reqData", d, rdat[d], eD[d]);
        chk("busClock", d, 8'(bclk[d]), 8'(eC[d]));
        chk("busSelect", d, 8'(bsel[d]), 8'(eSel[d]));
        chk("busMOSI", d, mosi[d], eM[d]);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) modelReset(d);
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) if (!rstN) modelReset(d); else modelStep(d);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rstN) modelReset(d);
                compareAll(d);
            end
        end
    end

    // Scenario monitor for the gapped multi-byte transaction on dut0/master1.
    bit mon = 0, seenG = 0;
    int strobes3 = 0, selBad = 0, clkBad = 0, earlyEnd = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (mon) begin
            if (stb[0][1]) strobes3++;
            if (gnt[0] != 2'b00 && bsel[0] != 2'b10) selBad++;
            if (rdy[0] != 2'b00 && bclk[0]) clkBad++;
            if (gnt[0] == 2'b00 && seenG && strobes3 < 3) earlyEnd++;
            if (gnt[0] != 2'b00) seenG = 1;
        end
    endtask

    task automatic pulseReset();
        #2 rstN = 1'b0;
        tick();
        rstN = 1'b1;
    endtask

    task automatic clearIn(input int d);
        req[d] = 0; valid[d] = 0; last[d] = 0;
    endtask

    initial begin
        logic [1:0] g1, g9, g17;
        logic [7:0] strData[4];
        int strCyc[4];
        int n, nStr, accepted;
        bit both;
        for (int d = 0; d < 2; d++) begin
            clearIn(d); sel[d] = 0; data[d] = 0; miso[d] = 0;
        end
        repeat (3) tick();
        chk("rst.grant", 0, 8'(gnt[0]), 8'h00);
        chk("rst.select", 0, 8'(bsel[0]), 8'h00);
        chk("rst.busClock", 1, 8'(bclk[1]), 8'h00);
        rstN = 1'b1;
        tick();

        // Single byte A5 from master0, MISO 3C.
        req[0] = 2'b01; sel[0] = 4'b0001; data[0] = 16'h00A5; valid[0] = 2'b01; last[0] = 2'b01;
        miso[0] = 8'h3C;
        tick();
        chk("t1.grant", 0, 8'(gnt[0]), 8'h01);
        chk("t1.select", 0, 8'(bsel[0]), 8'h01);
        tick();
        chk("t1.ready", 0, 8'(rdy[0]), 8'h01);
        tick();
        chk("t1.mosi", 0, mosi[0], 8'hA5);
        chk("t1.clkLow0", 0, 8'(bclk[0]), 8'h00);
        clearIn(0);
        tick(); chk("t1.clkLow1", 0, 8'(bclk[0]), 8'h00);
        tick(); chk("t1.clkHigh0", 0, 8'(bclk[0]), 8'h01);
        tick(); chk("t1.clkHigh1", 0, 8'(bclk[0]), 8'h01);
        tick();
        chk("t1.strobe", 0, 8'(stb[0]), 8'h01);
        chk("t1.data", 0, rdat[0], 8'h3C);
        chk("t1.doneSelect", 0, 8'(bsel[0]), 8'h00);
        chk("t1.doneGrant", 0, 8'(gnt[0]), 8'h00);
        tick();
        chk("t1.strobeOnce", 0, 8'(stb[0]), 8'h00);

        // Both masters contend from reset.
        pulseReset();
        req[0] = 2'b11; valid[0] = 2'b11; last[0] = 2'b11; sel[0] = 4'b1001; data[0] = 16'h5A3C;
        both = 0; g1 = 0; g9 = 0; g17 = 0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (gnt[0] == 2'b11) both = 1;
            if (c == 1) g1 = gnt[0];
            if (c == 9) g9 = gnt[0];
            if (c == 17) g17 = gnt[0];
        end
        clearIn(0);
        chk("t2.first", 0, 8'(g1), 8'h01);
        chk("t2.second", 0, 8'(g9), 8'h02);
        chk("t2.third", 0, 8'(g17), 8'h01);
        chk("t2.never11", 0, 8'(both), 8'h00);
        repeat (6) tick();

        // Master1, three bytes with two-cycle gaps.
        req[0] = 2'b10; sel[0] = 4'b1000; mon = 1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!rdy[0][1] && n < 20) begin tick(); n++; end
            chk("t3.readyTimeout", 0, 8'(rdy[0][1]), 8'h01);
            tick(); tick();
            valid[0] = 2'b10; last[0] = (i == 2) ? 2'b10 : 2'b00;
            data[0] = {8'(8'h11 * (i + 1)), 8'h00};
            tick();
            valid[0] = 0; last[0] = 0;
        end
        n = 0;
        while (gnt[0] != 2'b00 && n < 20) begin tick(); n++; end
        req[0] = 0; mon = 0;
        chk("t3.strobes", 0, 8'(strobes3), 8'd3);
        chk("t3.selectHeld", 0, 8'(selBad), 8'd0);
        chk("t3.clkLowInGap", 0, 8'(clkBad), 8'd0);
        chk("t3.noEarlyEnd", 0, 8'(earlyEnd), 8'd0);
        repeat (3) tick();

        // Master0 drops its request while waiting.
        req[0] = 2'b01; sel[0] = 4'b0010;
        tick(); tick();
        chk("t4.ready", 0, 8'(rdy[0]), 8'h01);
        req[0] = 0;
        tick();
        chk("t4.grantDone", 0, 8'(gnt[0]), 8'h00);
        chk("t4.readyDone", 0, 8'(rdy[0]), 8'h00);
        chk("t4.noClock", 0, 8'(bclk[0]), 8'h00);
        repeat (2) tick();

        // CLKDIV=1 streaming, four bytes.
        req[1] = 2'b01; valid[1] = 2'b01; sel[1] = 4'b0011;
        accepted = 0; nStr = 0;
        for (int c = 0; c < 40 && nStr < 4; c++) begin
            if (rdy[1][0]) begin
                data[1] = {8'h00, 8'(8'hA0 + accepted)};
                last[1] = (accepted == 3) ? 2'b01 : 2'b00;
                accepted++;
            end
            miso[1] = 8'(nStr + 1);
            tick();
            if (stb[1][0]) begin
                strData[nStr] = rdat[1]; strCyc[nStr] = c; nStr++;
            end
        end
        clearIn(1);
        chk("t5.strobes", 1, 8'(nStr), 8'd4);
        for (int i = 0; i < 4 && i < nStr; i++) chk("t5.data", 1, strData[i], 8'(i + 1));
        for (int i = 1; i < 4 && i < nStr; i++) chk("t5.period", 1, 8'(strCyc[i] - strCyc[i-1]), 8'd3);
        repeat (3) tick();

        // Reset during HIGH after master0 has owned the bus.
        req[0] = 2'b01; valid[0] = 2'b01; last[0] = 2'b01; data[0] = 16'h0077;
        n = 0;
        while (!stb[0][0] && n < 30) begin tick(); n++; end
        chk("t6.strobeTimeout", 0, 8'(stb[0]), 8'h01);
        clearIn(0);
        repeat (3) tick();
        req[0] = 2'b01; valid[0] = 2'b01; last[0] = 2'b01;
        n = 0;
        while (!bclk[0] && n < 30) begin tick(); n++; end
        chk("t6.highTimeout", 0, 8'(bclk[0]), 8'h01);
        req[0] = 2'b11;
        #2 rstN = 1'b0;
        #1;
        chk("t6.grant", 0, 8'(gnt[0]), 8'h00);
        chk("t6.busClock", 0, 8'(bclk[0]), 8'h00);
        chk("t6.select", 0, 8'(bsel[0]), 8'h00);
        chk("t6.strobe", 0, 8'(stb[0]), 8'h00);
        chk("t6.mosi", 0, mosi[0], 8'h00);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        chk("t6.req0Favoured", 0, 8'(gnt[0]), 8'h01);
        clearIn(0);
        repeat (6) tick();

        // Random traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int b = 0; b < 2; b++) if ($urandom_range(0, 5) == 0) req[d][b] = ~req[d][b];
                sel[d] = 4'($urandom);
                data[d] = 16'($urandom);
                valid[d] = 2'($urandom);
                last[d] = 2'($urandom) & 2'($urandom);
                miso[d] = 8'($urandom);
            end
            if ($urandom_range(0, 699) == 0) pulseReset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
